// File: rtl/turbo_stream_checker.sv
// Loopback checker for the turbo encoder serializer: reassembles {x1,z1,x2,z2}
// symbols from two-beat pairs and re-encodes x1/x2 through shadow RSCs to check parity and tail.
module turbo_stream_checker #(
  parameter int K    = 40,
  parameter int TAIL = 3,
  parameter int CW   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in0,
  input  logic          in1,
  input  logic          valid_in,
  output logic          data_out,
  output logic          data_valid,
  output logic          frame_done,
  output logic          frame_err,
  output logic [CW-1:0] err_cnt
);

  localparam int N    = K + TAIL;
  localparam int CNTW = $clog2(N + 1);
  localparam logic [CNTW-1:0] K_C    = CNTW'(K);
  localparam logic [CNTW-1:0] LAST_C = CNTW'(N - 1);

  typedef struct packed {
    logic       err;
    logic [2:0] nxt;
  } rsc_res_t;

  // s = {s1,s2,s3}; tail symbols force a zero shift-in so a bad tail x cannot disturb later tail checks
  function automatic rsc_res_t rsc_step(input logic [2:0] s, input logic x, input logic z,
                                        input logic tail);
    rsc_res_t r;
    logic     f;
    f = x ^ s[1] ^ s[0];
    if (tail) begin
      r.err = (x != (s[1] ^ s[0])) | (z != (s[2] ^ s[0]));
      r.nxt = {1'b0, s[2], s[1]};
    end else begin
      r.err = (z != (f ^ s[2] ^ s[0]));
      r.nxt = {f, s[2], s[1]};
    end
    return r;
  endfunction

  logic            phase_q, phase_d;
  logic            x1_q, x1_d, z1_q, z1_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      st1_q, st1_d, st2_q, st2_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic            data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_err_q, frame_err_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;

  rsc_res_t        r1, r2;
  logic            tail;
  logic [CW-1:0]   acc_nxt;

  always_comb begin
    phase_d      = phase_q;
    x1_d         = x1_q;
    z1_d         = z1_q;
    cnt_d        = cnt_q;
    st1_d        = st1_q;
    st2_d        = st2_q;
    acc_d        = acc_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    err_cnt_d    = err_cnt_q;
    tail         = (cnt_q >= K_C);
    r1           = rsc_step(st1_q, x1_q, z1_q, tail);
    r2           = rsc_step(st2_q, in0, in1, tail);
    acc_nxt      = ((r1.err | r2.err) && (acc_q != '1)) ? acc_q + 1'b1 : acc_q;

    if (valid_in && !phase_q) begin
      phase_d = 1'b1;
      x1_d    = in0;
      z1_d    = in1;
    end else if (valid_in && phase_q) begin
      phase_d = 1'b0;
      if (!tail) begin
        data_valid_d = 1'b1;
        data_out_d   = x1_q;
      end
      if (cnt_q == LAST_C) begin
        // frame boundary: publish totals and rearm for the next frame
        frame_done_d = 1'b1;
        err_cnt_d    = acc_nxt;
        frame_err_d  = (acc_nxt != '0);
        acc_d        = '0;
        cnt_d        = '0;
        st1_d        = 3'b000;
        st2_d        = 3'b000;
      end else begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        st1_d = r1.nxt;
        st2_d = r2.nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q      <= 1'b0;
      x1_q         <= 1'b0;
      z1_q         <= 1'b0;
      cnt_q        <= '0;
      st1_q        <= 3'b000;
      st2_q        <= 3'b000;
      acc_q        <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      phase_q      <= phase_d;
      x1_q         <= x1_d;
      z1_q         <= z1_d;
      cnt_q        <= cnt_d;
      st1_q        <= st1_d;
      st2_q        <= st2_d;
      acc_q        <= acc_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_turbo_stream_checker.sv
// Directed bench for turbo_stream_checker with K=8: clean, parity, error, gap, reset-abort and back-to-back frames.
module tb_turbo_stream_checker;
  localparam int K = 8, TAIL = 3, CW = 6, N = K + TAIL;

  // Hand-derived RSC1 stream for x1 = 1,0,0,0,0,0,0,0 (bit i = symbol i), tail included
  localparam logic [N-1:0] X1S = 11'b11000000001;
  localparam logic [N-1:0] Z1S = 11'b10101001111;
  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] BIT2 = 11'b00000000100;
  localparam logic [N-1:0] BIT5 = 11'b00000100000;
  localparam logic [N-1:0] BIT8 = 11'b00100000000;

  logic clk = 1'b0, reset, in0, in1, valid_in;
  logic data_out, data_valid, frame_done, frame_err;
  logic [CW-1:0] err_cnt;

  turbo_stream_checker #(.K(K), .TAIL(TAIL), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .valid_in(valid_in),
    .data_out(data_out), .data_valid(data_valid), .frame_done(frame_done),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  // Monitor: logs every output pulse with its cycle
  int   dv_n = 0, fd_n = 0;
  logic dv_dat[256];
  int   dv_cyc[256], dv_ec[256];
  int   fd_cyc[16], fd_cnt[16];
  logic fd_err[16];
  always @(negedge clk) begin
    if (data_valid) begin
      if (dv_n < 256) begin
        dv_dat[dv_n] = data_out; dv_cyc[dv_n] = cyc; dv_ec[dv_n] = int'(err_cnt);
      end
      dv_n++;
    end
    if (frame_done) begin
      if (fd_n < 16) begin
        fd_cyc[fd_n] = cyc; fd_cnt[fd_n] = int'(err_cnt); fd_err[fd_n] = frame_err;
      end
      fd_n++;
    end
  end

  int a0_cyc;
  int b_cyc[N];

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); valid_in = 1'b0; in0 = 1'b0; in1 = 1'b0;
    end
  endtask

  task automatic beat(input logic a, input logic b);
    @(negedge clk); valid_in = 1'b1; in0 = a; in1 = b;
  endtask

  task automatic send_frame(input logic [N-1:0] x1, input logic [N-1:0] z1,
                            input logic [N-1:0] x2, input logic [N-1:0] z2,
                            input int gap_sym, input int gap_len, input int nsym);
    for (int s = 0; s < nsym; s++) begin
      beat(x1[s], z1[s]);
      if (s == 0) a0_cyc = cyc;
      if (s == gap_sym) idle(gap_len);
      beat(x2[s], z2[s]);
      b_cyc[s] = cyc;
    end
  endtask

  // Shared frame-result check: count, data bits, timing, error totals
  task automatic check_frame(input string nm, input int d0, input int f0, input logic [N-1:0] xd,
                             input logic exp_fe, input int exp_cnt);
    checks++;
    if (dv_n - d0 !== K) begin failures++; $display("FAIL %s dv_count got=%0d exp=%0d", nm, dv_n - d0, K); end
    checks++;
    if (fd_n - f0 !== 1) begin failures++; $display("FAIL %s fd_count got=%0d exp=1", nm, fd_n - f0); end
    for (int i = 0; i < K; i++) begin
      checks++;
      if (dv_dat[d0+i] !== xd[i]) begin failures++; $display("FAIL %s data[%0d] got=%b exp=%b", nm, i, dv_dat[d0+i], xd[i]); end
    end
    checks++;
    if (fd_cyc[f0] !== b_cyc[N-1] + 1) begin failures++; $display("FAIL %s fd_cycle got=%0d exp=%0d", nm, fd_cyc[f0], b_cyc[N-1] + 1); end
    checks++;
    if (fd_err[f0] !== exp_fe) begin failures++; $display("FAIL %s frame_err got=%b exp=%b", nm, fd_err[f0], exp_fe); end
    checks++;
    if (fd_cnt[f0] !== exp_cnt) begin failures++; $display("FAIL %s err_cnt got=%0d exp=%0d", nm, fd_cnt[f0], exp_cnt); end
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_in = 1'b0; in0 = 1'b0; in1 = 1'b0;
    idle(2);
    checks++;
    if ({data_out, data_valid, frame_done, frame_err} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {data_out, data_valid, frame_done, frame_err});
    end
    checks++;
    if (err_cnt !== '0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    @(negedge clk); reset = 1'b1;
    idle(1);
  endtask

  task automatic test_clean();
    int d0, f0;
    d0 = dv_n; f0 = fd_n;
    send_frame(ZERO, ZERO, ZERO, ZERO, -1, 0, N);
    idle(3);
    check_frame("clean", d0, f0, ZERO, 1'b0, 0);
    checks++;
    if (dv_cyc[d0+7] !== b_cyc[7] + 1) begin failures++; $display("FAIL clean_dv_cycle got=%0d exp=%0d", dv_cyc[d0+7], b_cyc[7] + 1); end
  endtask

  task automatic test_parity_seq();
    int d0, f0;
    d0 = dv_n; f0 = fd_n;
    send_frame(X1S, Z1S, ZERO, ZERO, -1, 0, N);
    idle(3);
    check_frame("parity_seq", d0, f0, X1S, 1'b0, 0);
  endtask

  task automatic test_errors();
    int d0, f0;
    d0 = dv_n; f0 = fd_n;
    send_frame(X1S ^ BIT8, Z1S, ZERO, BIT2, -1, 0, N);
    idle(3);
    check_frame("errors", d0, f0, X1S, 1'b1, 2);
    checks++;
    if (err_cnt !== 6'd2) begin failures++; $display("FAIL errors_hold got=%0d exp=2", err_cnt); end
  endtask

  task automatic test_reset_abort();
    int d0, f0;
    send_frame(X1S, Z1S, ZERO, ZERO, -1, 0, 4);
    beat(1'b0, 1'b0);
    @(negedge clk); reset = 1'b0; valid_in = 1'b0;
    idle(1);
    checks++;
    if ({frame_err, err_cnt} !== 7'd0) begin failures++; $display("FAIL abort_reset_clear got=%b/%0d exp=0/0", frame_err, err_cnt); end
    @(negedge clk); reset = 1'b1;
    f0 = fd_n; d0 = dv_n;
    idle(2);
    checks++;
    if (fd_n !== f0) begin failures++; $display("FAIL abort_no_fd got=%0d exp=%0d", fd_n, f0); end
    send_frame(X1S, Z1S, ZERO, ZERO, -1, 0, N);
    idle(3);
    check_frame("after_abort", d0, f0, X1S, 1'b0, 0);
  endtask

  task automatic test_gap();
    int d0, f0, sp_ref;
    d0 = dv_n; f0 = fd_n;
    send_frame(X1S, Z1S, ZERO, ZERO, -1, 0, N);
    idle(3);
    sp_ref = dv_cyc[d0+3] - dv_cyc[d0+2];
    d0 = dv_n; f0 = fd_n;
    send_frame(X1S, Z1S, ZERO, ZERO, 3, 5, N);
    idle(3);
    check_frame("gap", d0, f0, X1S, 1'b0, 0);
    checks++;
    if (dv_cyc[d0+3] - dv_cyc[d0+2] !== sp_ref + 5) begin
      failures++; $display("FAIL gap_delay got=%0d exp=%0d", dv_cyc[d0+3] - dv_cyc[d0+2], sp_ref + 5);
    end
    checks++;
    if (dv_cyc[d0+4] - dv_cyc[d0+3] !== sp_ref) begin
      failures++; $display("FAIL gap_after got=%0d exp=%0d", dv_cyc[d0+4] - dv_cyc[d0+3], sp_ref);
    end
  endtask

  task automatic test_back_to_back();
    int d0, f0, bad;
    d0 = dv_n; f0 = fd_n;
    send_frame(X1S ^ BIT8, Z1S, ZERO, BIT2, -1, 0, N);
    send_frame(X1S, Z1S ^ BIT5, ZERO, BIT5, -1, 0, N);
    idle(3);
    checks++;
    if (fd_n - f0 !== 2) begin failures++; $display("FAIL b2b_fd_count got=%0d exp=2", fd_n - f0); end
    checks++;
    if (fd_cyc[f0] !== a0_cyc) begin failures++; $display("FAIL b2b_overlap_cycle got=%0d exp=%0d", fd_cyc[f0], a0_cyc); end
    checks++;
    if ({fd_err[f0], fd_cnt[f0][CW-1:0]} !== {1'b1, 6'd2}) begin
      failures++; $display("FAIL b2b_frame1 got=%b/%0d exp=1/2", fd_err[f0], fd_cnt[f0]);
    end
    checks++;
    if ({fd_err[f0+1], fd_cnt[f0+1][CW-1:0]} !== {1'b1, 6'd1}) begin
      failures++; $display("FAIL b2b_frame2 got=%b/%0d exp=1/1", fd_err[f0+1], fd_cnt[f0+1]);
    end
    bad = 0;
    for (int i = 0; i < K; i++) if (dv_ec[d0+K+i] != 2 || dv_dat[d0+K+i] !== X1S[i]) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL b2b_hold_and_data got=%0d bad pulses exp=0", bad); end
    checks++;
    if (err_cnt !== 6'd1) begin failures++; $display("FAIL b2b_final_hold got=%0d exp=1", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_parity_seq();
    test_errors();
    test_reset_abort();
    test_gap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
